// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Fetch/data port arbiter over one single-port memory, LED MMIO page.
//            Optional ARB_ROUND_ROBIN_EN: round-robin ties (else data wins).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
   parameter logic [7:0] MMIO_PAGE = 8'h7f
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req,
   input  logic [15:0] i_addr,
   output logic [15:0] i_rdata,
   output logic        i_ack,
   input  logic        d_req,
   input  logic [15:0] d_addr,
   input  logic [1:0]  d_we,
   input  logic [15:0] d_wdata,
   output logic [15:0] d_rdata,
   output logic        d_ack,
   output logic        m_en,
   output logic [14:0] m_addr,
   output logic [1:0]  m_we,
   output logic [15:0] m_wdata,
   input  logic [15:0] m_rdata,
   output logic [15:0] led
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   logic [1:0]  state, state_next;
   logic        port_d;
   logic [14:0] waddr;
   logic [1:0]  we_q;
   logic [15:0] wdata_q;
   logic        grant_d, load, load_d;
   logic        is_mmio, led_sel;
   logic [15:0] resp_data;

`ifdef ARB_ROUND_ROBIN_EN
   logic        last_d;
`endif

   assign is_mmio = (waddr[14:7] == MMIO_PAGE);
   assign led_sel = is_mmio && (waddr[6:0] == 7'd0);

   // Tie-break in IDLE; in RESP the other port is taken without arbitration.
   always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
      grant_d = d_req & (~i_req | ~last_d);
`else
      grant_d = d_req;
`endif
      load   = 1'b0;
      load_d = 1'b0;
      case (state)
         ST_IDLE: begin
            load   = i_req | d_req;
            load_d = grant_d;
         end
         ST_RESP: begin
            load_d = ~port_d;
            load   = port_d ? i_req : d_req;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = ST_IDLE;
      case (state)
         ST_IDLE:   state_next = load ? ST_ACCESS : ST_IDLE;
         ST_ACCESS: state_next = ST_RESP;
         ST_RESP:   state_next = load ? ST_ACCESS : ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         port_d  <= 1'b0;
         waddr   <= 15'd0;
         we_q    <= 2'b00;
         wdata_q <= 16'h0000;
      end else if (load) begin
         port_d  <= load_d;
         waddr   <= load_d ? d_addr[15:1] : i_addr[15:1];
         we_q    <= load_d ? d_we : 2'b00;
         wdata_q <= load_d ? d_wdata : 16'h0000;
      end
   end

`ifdef ARB_ROUND_ROBIN_EN
   // Reset value "data last" hands the first tie to the fetch port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    last_d <= 1'b1;
      else if (load) last_d <= load_d;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led <= 16'h0000;
      end else if (state == ST_ACCESS && port_d && led_sel) begin
         if (we_q[0]) led[15:8] <= wdata_q[15:8];
         if (we_q[1]) led[7:0]  <= wdata_q[7:0];
      end
   end

   always_comb begin
      m_en    = (state == ST_ACCESS) && !is_mmio;
      m_addr  = waddr;
      m_we    = m_en ? we_q : 2'b00;
      m_wdata = wdata_q;

      resp_data = 16'h0000;
      if (we_q == 2'b00) begin
         if (!is_mmio)              resp_data = m_rdata;
         else if (port_d && led_sel) resp_data = led;
      end

      i_ack   = (state == ST_RESP) && !port_d;
      d_ack   = (state == ST_RESP) && port_d;
      i_rdata = i_ack ? resp_data : 16'h0000;
      d_rdata = d_ack ? resp_data : 16'h0000;
   end

endmodule

`default_nettype wire
